// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg : operation codes and shared defaults for alu_muldiv         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package alu_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [3:0] {
    FOP_ADD  = 4'd0,
    FOP_SUB  = 4'd1,
    FOP_SLL  = 4'd2,
    FOP_SRL  = 4'd3,
    FOP_SRA  = 4'd4,
    FOP_AND  = 4'd5,
    FOP_OR   = 4'd6,
    FOP_XOR  = 4'd7,
    FOP_IMM  = 4'd8,
    FOP_MUL  = 4'd9,
    FOP_DIVU = 4'd10,
    FOP_REMU = 4'd11
  } fop_t;

  function automatic logic is_iterative(fop_t f);
    return (f == FOP_MUL) || (f == FOP_DIVU) || (f == FOP_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_muldiv_if : request/response handshake bundle for alu_muldiv     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface alu_muldiv_if
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  fop_t             fop;
  logic [WIDTH-1:0] rda;
  logic [WIDTH-1:0] rdb;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             Z;
  logic             N;
  logic             C;
  logic             V;

  modport master (
    output in_valid, fop, rda, rdb, out_ready,
    input  in_ready, out_valid, result, Z, N, C, V
  );

  modport slave (
    input  in_valid, fop, rda, rdb, out_ready,
    output in_ready, out_valid, result, Z, N, C, V
  );

endinterface
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_iter : one-bit-per-cycle shift-add multiply / restoring divide|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  fop_t             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  localparam logic [SHW:0] LAST = (SHW+1)'(WIDTH - 1);

  logic             running;
  logic [SHW:0]     cnt;
  fop_t             op_r;
  // acc: product (MUL) or partial remainder (DIVU/REMU)
  // opa: shifting multiplicand, or dividend shifting into the quotient
  // opb: shifting multiplier, or constant divisor
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;

  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] opa_nxt;
  logic [WIDTH-1:0] opb_nxt;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             fits;

  assign shifted = {acc, opa[WIDTH-1]};
  assign trial   = shifted - {1'b0, opb};
  assign fits    = ~trial[WIDTH];

  always_comb begin
    acc_nxt = acc;
    opa_nxt = opa;
    opb_nxt = opb;
    if (op_r == FOP_MUL) begin
      acc_nxt = opb[0] ? (acc + opa) : acc;
      opa_nxt = {opa[WIDTH-2:0], 1'b0};
      opb_nxt = {1'b0, opb[WIDTH-1:1]};
    end else begin
      // A zero divisor always "fits", which yields all-ones quotient and rda remainder
      acc_nxt = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
      opa_nxt = {opa[WIDTH-2:0], fits};
    end
  end

  assign done = running && (cnt == LAST);
  assign res  = (op_r == FOP_DIVU) ? opa_nxt : acc_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      op_r    <= FOP_MUL;
      acc     <= '0;
      opa     <= '0;
      opb     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      op_r    <= op;
      acc     <= '0;
      opa     <= a;
      opb     <= b;
    end else if (running) begin
      acc <= acc_nxt;
      opa <= opa_nxt;
      opb <= opb_nxt;
      if (done) begin
        running <= 1'b0;
        cnt     <= '0;
      end else begin
        cnt <= cnt + (SHW+1)'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_muldiv : handshaked ALU with iterative multiply/divide           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic         clk,
  input  logic         rst,
  alu_muldiv_if.slave  bus
);

  generate
    if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
      $error("alu_muldiv: WIDTH must be a power of two and at least 8");
    end
  endgenerate

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] res_q;
  logic             z_q;
  logic             n_q;
  logic             c_q;
  logic             v_q;

  logic             accept;
  logic             start_iter;
  logic             iter_done;
  logic [WIDTH-1:0] iter_res;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.result    = res_q;
  assign bus.Z         = z_q;
  assign bus.N         = n_q;
  assign bus.C         = c_q;
  assign bus.V         = v_q;

  assign accept     = bus.in_valid && (state == S_IDLE);
  assign start_iter = accept && is_iterative(bus.fop);

  assign sum_ext  = {1'b0, bus.rda} + {1'b0, bus.rdb};
  assign diff_ext = {1'b0, bus.rda} - {1'b0, bus.rdb};
  assign shamt    = bus.rdb[SHW-1:0];

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.fop)
      FOP_ADD: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (bus.rda[WIDTH-1] == bus.rdb[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != bus.rda[WIDTH-1]);
      end
      FOP_SUB: begin
        alu_res = diff_ext[WIDTH-1:0];
        alu_c   = ~diff_ext[WIDTH];
        alu_v   = (bus.rda[WIDTH-1] != bus.rdb[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != bus.rda[WIDTH-1]);
      end
      FOP_SLL: alu_res = bus.rda << shamt;
      FOP_SRL: alu_res = bus.rda >> shamt;
      FOP_SRA: alu_res = WIDTH'($signed(bus.rda) >>> shamt);
      FOP_AND: alu_res = bus.rda & bus.rdb;
      FOP_OR:  alu_res = bus.rda | bus.rdb;
      FOP_XOR: alu_res = bus.rda ^ bus.rdb;
      FOP_IMM: alu_res = bus.rdb;
      default: alu_res = '0;
    endcase
  end

  muldiv_iter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_muldiv_iter (
    .clk   (clk),
    .rst   (rst),
    .start (start_iter),
    .op    (bus.fop),
    .a     (bus.rda),
    .b     (bus.rdb),
    .done  (iter_done),
    .res   (iter_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      res_q <= '0;
      z_q   <= 1'b0;
      n_q   <= 1'b0;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_iterative(bus.fop)) begin
              state <= S_BUSY;
            end else begin
              state <= S_DONE;
              res_q <= alu_res;
              z_q   <= (alu_res == '0);
              n_q   <= alu_res[WIDTH-1];
              c_q   <= alu_c;
              v_q   <= alu_v;
            end
          end
        end
        S_BUSY: begin
          if (iter_done) begin
            state <= S_DONE;
            res_q <= iter_res;
            z_q   <= (iter_res == '0);
            n_q   <= iter_res[WIDTH-1];
            c_q   <= 1'b0;
            v_q   <= 1'b0;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits, SHALL be at least 8 and a power of two.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount bits taken from rdb.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 fop  input  4  operation code (fop_t).
REQ-008 rda, rdb  input  WIDTH  operands.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  WIDTH  registered result.
REQ-012 Z, N, C, V  output  1 each  registered zero, negative, carry, overflow flags.

Function
REQ-013 fop encodings SHALL be: ADD=0, SUB=1, SLL=2, SRL=3, SRA=4, AND=5, OR=6, XOR=7, IMM=8, MUL=9, DIVU=10, REMU=11; codes 12-15 SHALL give result 0.
REQ-014 FSM states IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 A request is accepted on a clock edge with in_valid && in_ready; operands and fop SHALL be captured there.
REQ-016 Single-cycle ops (0-8, 12-15): IDLE->DONE on accept; out_valid asserted the cycle after accept.
REQ-017 MUL/DIVU/REMU: IDLE->BUSY on accept; iterative, one bit per cycle, WIDTH cycles in BUSY, then DONE; out_valid asserted exactly WIDTH+1 cycles after accept.
REQ-018 DONE->IDLE on an edge with out_ready=1; otherwise result and flags SHALL hold stable.
REQ-019 ADD/SUB results SHALL be modulo 2^WIDTH.
REQ-020 C for ADD SHALL be the true carry-out of bit WIDTH-1; for SUB, C=1 iff rda >= rdb unsigned (no borrow); C=0 for all other ops.
REQ-021 V for ADD: operands same sign, result sign differs; for SUB: operand signs differ, result sign differs from rda; V=0 otherwise.
REQ-022 Shifts SHALL use only rdb[SHW-1:0]; SRA SHALL replicate rda[WIDTH-1].
REQ-023 IMM result SHALL equal rdb.
REQ-024 MUL result SHALL be the low WIDTH bits of the unsigned product.
REQ-025 DIVU by zero: result all ones; REMU by zero: result rda; C=V=0.
REQ-026 Z = (result==0), N = result[WIDTH-1], for every op, computed from the final result.
REQ-027 in_valid while not in IDLE SHALL be ignored; no request is queued.

Reset
REQ-028 On rst: state IDLE, in_ready 1, out_valid 0, result 0, Z 0, N 0, C 0, V 0, iteration counter 0.
REQ-029 rst during BUSY or DONE SHALL abandon the operation with no output produced.

Structure
REQ-030 fop_t enum and WIDTH default SHALL live in shared package alu_pkg, reused by the combinational ALU.
REQ-031 Iterative shift-add multiply / restoring divide SHALL be sub-module muldiv_iter (start, op, a, b -> done, res), with its own counter of SHW+1 bits.

Verification (WIDTH=32)
REQ-032 ADD 0xFFFFFFFF+1 -> result 0, Z=1, C=1, V=0, N=0, out_valid 1 cycle after accept.
REQ-033 SUB 0x80000000-1 -> 0x7FFFFFFF, V=1, C=1, N=0; SUB 1-2 -> 0xFFFFFFFF, C=0, N=1.
REQ-034 SRA 0x80000000 by rdb=33 -> 0xC0000000, N=1; SLL 1 by rdb=32 -> 1.
REQ-035 MUL 0x00010000*0x00010000 -> 0, Z=1, out_valid exactly 33 cycles after accept; in_ready 0 throughout.
REQ-036 DIVU 100/7 -> 14, REMU 100/7 -> 2; DIVU 7/0 -> 0xFFFFFFFF, REMU 7/0 -> 7.
REQ-037 out_ready held 0 for 5 cycles in DONE -> result/flags stable, in_ready 0; rst asserted mid-DIVU -> next cycle in_ready 1, out_valid 0, result 0.
